game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3: balls per game, legal range 1..3.
REQ-002 Parameter SERVE_DELAY, default 60: iTick pulses in SERVE before release, legal range 1..255.
REQ-003 iCLK  input  1  system clock, the same clock that drives the ball stage.
REQ-004 iRST_n  input  1  reset, asynchronous, active-low.
REQ-005 iTick  input  1  one-cycle pulse, one per frame, synchronous to iCLK.
REQ-006 iStart  input  1  debounced start key, level, active-high, synchronous to iCLK.
REQ-007 iFlag  input  4  ball-stage status: [1:0] X event, [3:2] Y event; 01 = paddle hit on [3:2]; 1111 = ball lost.
REQ-008 oBall_RST_n  output  1  active-low hold/re-centre for the ball stage.
REQ-009 oScore  output  16  score, 4 BCD digits, [15:12] most significant.
REQ-010 oLives  output  2  balls remaining.
REQ-011 oState  output  2  FSM state: 0 IDLE, 1 SERVE, 2 PLAY, 3 OVER.
REQ-012 oGame_Over  output  1  high while in OVER.

Function
REQ-013 The block SHALL register iStart once and SHALL define start_evt as iStart=1 while the registered copy is 0.
REQ-014 The block SHALL register iFlag every cycle into flag_q.
REQ-015 The block SHALL define hit_evt as iFlag[3:2]=01 and flag_q[3:2]!=01.
REQ-016 The block SHALL define miss_evt as iFlag=1111 and flag_q!=1111.
REQ-017 hit_evt and miss_evt are mutually exclusive by encoding, and no priority logic SHALL be added.
REQ-018 In IDLE, start_evt SHALL cause a transition to SERVE, clear oScore to 0000, load oLives=LIVES_INIT and load the serve counter with SERVE_DELAY.
REQ-019 In SERVE, each iTick SHALL decrement the serve counter.
REQ-020 In SERVE, iTick with counter=1 SHALL cause a transition to PLAY, so release occurs on exactly the SERVE_DELAY-th tick.
REQ-021 In PLAY, hit_evt SHALL increment oScore by 1 in BCD with per-digit carry (9->0, carry into next digit).
REQ-022 oScore SHALL saturate at 9999 and SHALL never wrap.
REQ-023 In PLAY, miss_evt with oLives>1 SHALL decrement oLives, transition to SERVE and reload the counter with SERVE_DELAY.
REQ-024 In PLAY, miss_evt with oLives=1 SHALL set oLives=0 and transition to OVER.
REQ-025 In OVER, oScore SHALL hold its value.
REQ-026 In OVER, start_evt SHALL behave exactly as in IDLE (score cleared, lives reloaded, enter SERVE).
REQ-027 start_evt SHALL be ignored in SERVE and PLAY.
REQ-028 hit_evt and miss_evt SHALL be ignored outside PLAY.
REQ-029 oBall_RST_n SHALL be a registered output equal to (next_state==PLAY), so it is high in the same cycle oState first reads 2.
REQ-030 oBall_RST_n SHALL be low in the same cycle oState leaves PLAY.
REQ-031 oGame_Over SHALL be a registered output equal to (next_state==OVER).
REQ-032 iTick and start_evt arriving in the same cycle in IDLE SHALL enter SERVE with the full SERVE_DELAY loaded; that tick is not counted.
REQ-033 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-034 While iRST_n=0, the block SHALL hold: state IDLE, oScore=0000, oLives=LIVES_INIT, serve counter 0, flag_q=0000, start register 0, oBall_RST_n=0, oGame_Over=0.
REQ-035 Reset asserted mid-game SHALL take effect immediately and asynchronously, with no event logged.
REQ-036 After reset release, the block SHALL require a fresh start_evt to begin a game; iStart held high through reset release SHALL NOT start a game.

Verification
REQ-037 Serve timing: reset, then pulse iStart, then 60 iTicks -> oState=1 through tick 59; oState=2 and oBall_RST_n=1 on the cycle after tick 60; oScore=0000, oLives=3.
REQ-038 Hit counting: in PLAY, drive iFlag 0000->0100 for 5 cycles, then 1000->0100 repeated 9 times -> oScore=0010 (10 hits), a held flag counted once per entry.
REQ-039 BCD carry and saturation: preset score via 9999 hits -> oScore=9999; one further hit -> oScore stays 9999.
REQ-040 Life loss: in PLAY, iFlag=1111 -> oLives 3->2, oState=1, oBall_RST_n=0 in the same cycle; after 60 iTicks play resumes with score unchanged.
REQ-041 Game over and restart: three misses -> oLives=0, oState=3, oGame_Over=1, score held; iStart rising -> oState=1, oScore=0000, oLives=3, oGame_Over=0.
REQ-042 Async reset and held start: assert iRST_n=0 mid-PLAY between clock edges -> outputs reach reset values before the next edge; release with iStart held high -> oState remains 0.

Source files
------------

// File: rtl/game_ctrl_if.sv
// Ball-game control bus: frame tick, start key and ball-stage flags in;
// ball hold, score, lives, state and game-over status out.
interface game_ctrl_if;
    logic        iTick;
    logic        iStart;
    logic [3:0]  iFlag;
    logic        oBall_RST_n;
    logic [15:0] oScore;
    logic [1:0]  oLives;
    logic [1:0]  oState;
    logic        oGame_Over;

    modport master (
        output iTick, iStart, iFlag,
        input  oBall_RST_n, oScore, oLives, oState, oGame_Over
    );

    modport slave (
        input  iTick, iStart, iFlag,
        output oBall_RST_n, oScore, oLives, oState, oGame_Over
    );
endinterface

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE -> SERVE (timed hold) -> PLAY -> SERVE/OVER, with a
// saturating 4-digit BCD score and a lives counter. Every output is a flop.
module game_ctrl #(
    parameter int LIVES_INIT  = 3,
    parameter int SERVE_DELAY = 60
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

    localparam logic [1:0] LIVES_L = 2'(LIVES_INIT);
    localparam logic [7:0] DELAY_L = 8'(SERVE_DELAY);

    state_t      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  flag_q;
    logic        start_q;
    logic        arm_q;
    logic        ball_rst_n_q;
    logic        game_over_q;

    logic        start_evt, hit_evt, miss_evt;
    logic [15:0] score_inc;
    logic        carry;

    // A start key still held from before reset must be released once before it can start a game.
    assign start_evt = bus.iStart & ~start_q & arm_q;
    assign hit_evt   = (bus.iFlag[3:2] == 2'b01) && (flag_q[3:2] != 2'b01);
    assign miss_evt  = (bus.iFlag == 4'hF) && (flag_q != 4'hF);

    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (score_q[i*4 +: 4] == 4'd9) begin
                    score_inc[i*4 +: 4] = 4'd0;
                end else begin
                    score_inc[i*4 +: 4] = score_q[i*4 +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, OVER: begin
                if (start_evt) begin
                    state_d = SERVE;
                    score_d = 16'h0000;
                    lives_d = LIVES_L;
                    cnt_d   = DELAY_L;
                end
            end
            SERVE: begin
                if (bus.iTick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = PLAY;
                end
            end
            PLAY: begin
                if (hit_evt) begin
                    if (score_q != 16'h9999) score_d = score_inc;
                end else if (miss_evt) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        state_d = SERVE;
                        cnt_d   = DELAY_L;
                    end else begin
                        lives_d = 2'd0;
                        state_d = OVER;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= IDLE;
            score_q      <= 16'h0000;
            lives_q      <= LIVES_L;
            cnt_q        <= 8'd0;
            flag_q       <= 4'h0;
            start_q      <= 1'b0;
            arm_q        <= 1'b0;
            ball_rst_n_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
            flag_q       <= bus.iFlag;
            start_q      <= bus.iStart;
            arm_q        <= arm_q | ~bus.iStart;
            ball_rst_n_q <= (state_d == PLAY);
            game_over_q  <= (state_d == OVER);
        end
    end

    assign bus.oState      = state_q;
    assign bus.oScore      = score_q;
    assign bus.oLives      = lives_q;
    assign bus.oBall_RST_n = ball_rst_n_q;
    assign bus.oGame_Over  = game_over_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenario with literal expectations, then random
// stimulus, all checked each cycle against an integer-score game model.
module tb_game_ctrl;
    localparam int LIVES = 3;
    localparam int SD    = 60;

    logic iCLK;
    logic iRST_n;
    int   checks = 0;
    int   errors = 0;

    game_ctrl_if bus();

    game_ctrl #(.LIVES_INIT(LIVES), .SERVE_DELAY(SD)) dut (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .bus   (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Model: phase 0 idle, 1 serving, 2 playing, 3 over; score kept as a plain integer.
    int         m_phase = 0;
    int         m_score = 0;
    int         m_lives = LIVES;
    int         m_wait  = 0;
    logic       m_pstart = 1'b0;
    logic       m_armed  = 1'b0;
    logic [3:0] m_pflag  = 4'h0;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge iCLK or negedge iRST_n);
            if (!iRST_n) begin
                m_phase = 0; m_score = 0; m_lives = LIVES; m_wait = 0;
                m_pstart = 1'b0; m_armed = 1'b0; m_pflag = 4'h0;
            end else begin
                automatic bit press = bus.iStart && !m_pstart && m_armed;
                automatic bit hit   = (bus.iFlag[3:2] == 2'b01) && (m_pflag[3:2] != 2'b01);
                automatic bit miss  = (bus.iFlag == 4'hF) && (m_pflag != 4'hF);
                if ((m_phase == 0 || m_phase == 3) && press) begin
                    m_phase = 1; m_score = 0; m_lives = LIVES; m_wait = SD;
                end else if (m_phase == 1 && bus.iTick) begin
                    m_wait--;
                    if (m_wait == 0) m_phase = 2;
                end else if (m_phase == 2 && hit) begin
                    if (m_score < 9999) m_score++;
                end else if (m_phase == 2 && miss) begin
                    m_lives--;
                    if (m_lives > 0) begin
                        m_phase = 1; m_wait = SD;
                    end else begin
                        m_phase = 3;
                    end
                end
                m_pstart = bus.iStart;
                m_pflag  = bus.iFlag;
                if (!bus.iStart) m_armed = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge iCLK);
            chk("m_state", 16'(bus.oState), 16'(m_phase));
            chk("m_score", bus.oScore, to_bcd(m_score));
            chk("m_lives", 16'(bus.oLives), 16'(m_lives));
            chk("m_ball", 16'(bus.oBall_RST_n), 16'(m_phase == 2));
            chk("m_over", 16'(bus.oGame_Over), 16'(m_phase == 3));
        end
    end

    task automatic step(input logic t, input logic s, input logic [3:0] f);
        bus.iTick = t; bus.iStart = s; bus.iFlag = f;
        @(negedge iCLK);
    endtask

    initial begin
        iRST_n = 1'b0;
        bus.iTick = 1'b0; bus.iStart = 1'b0; bus.iFlag = 4'h0;
        repeat (3) @(negedge iCLK);
        iRST_n = 1'b1;
        step(0, 0, 4'h0);
        chk("rst_state", 16'(bus.oState), 16'd0);
        chk("rst_score", bus.oScore, 16'h0000);
        chk("rst_lives", 16'(bus.oLives), 16'd3);
        chk("rst_ball", 16'(bus.oBall_RST_n), 16'd0);

        // Serve timing
        step(0, 1, 4'h0);
        chk("serve_enter", 16'(bus.oState), 16'd1);
        for (int i = 0; i < 59; i++) step(1, 0, 4'h0);
        chk("serve_tick59", 16'(bus.oState), 16'd1);
        step(1, 0, 4'h0);
        chk("serve_tick60", 16'(bus.oState), 16'd2);
        chk("serve_ball", 16'(bus.oBall_RST_n), 16'd1);
        chk("serve_lives", 16'(bus.oLives), 16'd3);

        // Held flag counts once per entry
        for (int i = 0; i < 5; i++) step(0, 0, 4'b0100);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 4'b1000);
            step(0, 0, 4'b0100);
        end
        chk("hits10", bus.oScore, 16'h0010);

        // Life loss and resume
        step(0, 0, 4'hF);
        chk("miss_lives", 16'(bus.oLives), 16'd2);
        chk("miss_state", 16'(bus.oState), 16'd1);
        chk("miss_ball", 16'(bus.oBall_RST_n), 16'd0);
        for (int i = 0; i < SD; i++) step(1, 0, 4'h0);
        chk("resume_state", 16'(bus.oState), 16'd2);
        chk("resume_score", bus.oScore, 16'h0010);

        // Carry chain up to saturation
        for (int i = 0; i < 9989; i++) begin
            step(0, 0, 4'h0);
            step(0, 0, 4'b0100);
        end
        chk("score_9999", bus.oScore, 16'h9999);
        step(0, 0, 4'h0);
        step(0, 0, 4'b0100);
        chk("score_sat", bus.oScore, 16'h9999);

        // Game over and restart
        step(0, 0, 4'hF);
        for (int i = 0; i < SD; i++) step(1, 0, 4'h0);
        step(0, 0, 4'hF);
        chk("over_lives", 16'(bus.oLives), 16'd0);
        chk("over_state", 16'(bus.oState), 16'd3);
        chk("over_flag", 16'(bus.oGame_Over), 16'd1);
        step(0, 0, 4'h0);
        step(0, 0, 4'b0100);
        chk("over_hold", bus.oScore, 16'h9999);
        step(0, 1, 4'h0);
        chk("restart_state", 16'(bus.oState), 16'd1);
        chk("restart_score", bus.oScore, 16'h0000);
        chk("restart_lives", 16'(bus.oLives), 16'd3);
        chk("restart_over", 16'(bus.oGame_Over), 16'd0);

        // Async reset mid-play with start held through release
        step(0, 0, 4'h0);
        for (int i = 0; i < SD; i++) step(1, 0, 4'h0);
        step(0, 0, 4'b0100);
        bus.iStart = 1'b1;
        #2 iRST_n = 1'b0;
        #1;
        chk("arst_state", 16'(bus.oState), 16'd0);
        chk("arst_score", bus.oScore, 16'h0000);
        chk("arst_ball", 16'(bus.oBall_RST_n), 16'd0);
        @(negedge iCLK);
        @(negedge iCLK);
        iRST_n = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 1, 4'h0);
        chk("held_start", 16'(bus.oState), 16'd0);
        step(0, 0, 4'h0);
        step(0, 1, 4'h0);
        chk("fresh_start", 16'(bus.oState), 16'd1);

        // Random play with occasional mid-cycle resets
        for (int n = 0; n < 30000; n++) begin
            automatic int r = int'($urandom_range(0, 39));
            automatic logic [3:0] f;
            if (r < 12)       f = 4'b0100;
            else if (r == 12) f = 4'hF;
            else if (r < 20)  f = 4'($urandom);
            else              f = 4'h0;
            if ($urandom_range(0, 19) == 0) bus.iStart = ~bus.iStart;
            bus.iTick = ($urandom_range(0, 2) == 0);
            bus.iFlag = f;
            if ($urandom_range(0, 2999) == 0) begin
                #2 iRST_n = 1'b0;
                @(negedge iCLK);
                iRST_n = 1'b1;
            end else begin
                @(negedge iCLK);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
